ccu_mem_arbiter: RTL

- Core-side arbiter that shares the single line-fill/writeback memory port among CCU_NUM_REQ requesters, e.g. the instruction fetch queue (req 0) and the data miss/victim queue (req 1).
- Grants one requester at a time using round-robin priority and sequences the memory handshake for that transaction.
- Returns the read line and a done pulse to the winning requester.
- Only one transaction is outstanding at a time.

---
 rtl/ccu_mem_arbiter_pkg.sv | 28 ++
 rtl/ccu_rr_picker.sv | 38 +++
 rtl/ccu_mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ccu_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// ccu_mem_arbiter_pkg: shared types and sizing helpers for the CCU memory arbiter.
// Revision: 1.0
// ============================================================================
package ccu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        CCU_ARB_STATE_IDLE = 2'd0,
        CCU_ARB_STATE_REQ  = 2'd1,
        CCU_ARB_STATE_WAIT = 2'd2,
        CCU_ARB_STATE_RESP = 2'd3
    } ccu_arb_state_e;

    function automatic int ccu_line_width(input int line_size);
        return line_size * 8;
    endfunction

    function automatic int ccu_offset_width(input int line_size);
        return $clog2(line_size);
    endfunction

    localparam int CCU_DEF_LINE_SIZE    = 32;
    localparam int CCU_DEF_LINE_WIDTH   = ccu_line_width(CCU_DEF_LINE_SIZE);
    localparam int CCU_DEF_OFFSET_WIDTH = ccu_offset_width(CCU_DEF_LINE_SIZE);

endpackage
`default_nettype wire

// File: rtl/ccu_rr_picker.sv
`default_nettype none
// ============================================================================
// ccu_rr_picker: combinational round-robin pick, first set bit at or above ptr.
// Revision: 1.0
// ============================================================================
module ccu_rr_picker
    import ccu_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic                 o_valid,
    output logic [IDX_WIDTH-1:0] o_idx
);

    int w_cand;

    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = IDX_WIDTH'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// ccu_mem_arbiter: round-robin owner of the shared line-fill/writeback memory port.
// Revision: 1.0
// ============================================================================
module ccu_mem_arbiter
    import ccu_mem_arbiter_pkg::*;
#(
    parameter int OPTN_ADDR_WIDTH = 32,
    parameter int OPTN_LINE_SIZE  = 32,
    parameter int CCU_NUM_REQ     = 2
) (
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic [CCU_NUM_REQ-1:0]                     i_req_valid,
    input  logic [CCU_NUM_REQ-1:0]                     i_req_we,
    input  logic [CCU_NUM_REQ*OPTN_ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [CCU_NUM_REQ*OPTN_LINE_SIZE*8-1:0]    i_req_data,
    output logic [CCU_NUM_REQ-1:0]                     o_req_done,
    output logic [OPTN_LINE_SIZE*8-1:0]                o_req_data,
    output logic                                       o_mem_en,
    output logic                                       o_mem_we,
    output logic [OPTN_ADDR_WIDTH-1:0]                 o_mem_addr,
    output logic [OPTN_LINE_SIZE*8-1:0]                o_mem_data,
    input  logic                                       i_mem_rdy,
    input  logic                                       i_mem_done,
    input  logic [OPTN_LINE_SIZE*8-1:0]                i_mem_data
);

    localparam int c_line_width   = ccu_line_width(OPTN_LINE_SIZE);
    localparam int c_offset_width = ccu_offset_width(OPTN_LINE_SIZE);
    localparam int c_idx_width    = $clog2(CCU_NUM_REQ);

    localparam logic [OPTN_ADDR_WIDTH-1:0] c_addr_mask =
        ~OPTN_ADDR_WIDTH'((1 << c_offset_width) - 1);
    localparam logic [CCU_NUM_REQ-1:0] c_done_base = CCU_NUM_REQ'(1);
    localparam logic [c_idx_width-1:0] c_last_idx  = c_idx_width'(CCU_NUM_REQ - 1);

    ccu_arb_state_e           r_state;
    logic [c_idx_width-1:0]   r_ptr;
    logic [c_idx_width-1:0]   r_winner;

    logic                       w_pick_valid;
    logic [c_idx_width-1:0]     w_pick_idx;
    logic [OPTN_ADDR_WIDTH-1:0] w_addr_arr [CCU_NUM_REQ];
    logic [c_line_width-1:0]    w_data_arr [CCU_NUM_REQ];

    for (genvar k = 0; k < CCU_NUM_REQ; k++) begin : g_unpack
        assign w_addr_arr[k] = i_req_addr[k*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
        assign w_data_arr[k] = i_req_data[k*c_line_width +: c_line_width];
    end

    ccu_rr_picker #(
        .NUM_REQ   (CCU_NUM_REQ),
        .IDX_WIDTH (c_idx_width)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= CCU_ARB_STATE_IDLE;
            r_ptr      <= '0;
            r_winner   <= '0;
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_req_done <= '0;
            o_req_data <= '0;
        end else begin
            case (r_state)
                CCU_ARB_STATE_IDLE: begin
                    o_req_done <= '0;
                    if (w_pick_valid) begin
                        r_winner   <= w_pick_idx;
                        o_mem_we   <= i_req_we[w_pick_idx];
                        o_mem_addr <= w_addr_arr[w_pick_idx] & c_addr_mask;
                        o_mem_data <= w_data_arr[w_pick_idx];
                        o_mem_en   <= 1'b1;
                        r_state    <= CCU_ARB_STATE_REQ;
                    end
                end
                CCU_ARB_STATE_REQ: begin
                    // A done without the accept is not for us; only act once rdy is seen.
                    if (i_mem_rdy) begin
                        o_mem_en <= 1'b0;
                        if (i_mem_done) begin
                            o_req_data <= i_mem_data;
                            o_req_done <= c_done_base << r_winner;
                            r_state    <= CCU_ARB_STATE_RESP;
                        end else begin
                            r_state    <= CCU_ARB_STATE_WAIT;
                        end
                    end
                end
                CCU_ARB_STATE_WAIT: begin
                    if (i_mem_done) begin
                        o_req_data <= i_mem_data;
                        o_req_done <= c_done_base << r_winner;
                        r_state    <= CCU_ARB_STATE_RESP;
                    end
                end
                CCU_ARB_STATE_RESP: begin
                    o_req_done <= '0;
                    r_ptr      <= (r_winner == c_last_idx) ? '0 : r_winner + 1'b1;
                    r_state    <= CCU_ARB_STATE_IDLE;
                end
                default: begin
                    r_state <= CCU_ARB_STATE_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
